// File: rtl/serial_adder_driver.sv
// Serializes a parallel operand pair LSB-first into an external serial adder and reassembles the sum.
// Latency: beats in cycles T+1..T+WIDTH after the handshake at edge T; out_vld pulses in cycle T+WIDTH+1.
// Backpressure: in_rdy is low while shifting; hold inserts bubbles without advancing the operation.
module serial_adder_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             hold,
  output logic             ser_vld,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_last,
  input  logic             ser_sum,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_sum
);

  // Counter needs at least one bit so WIDTH = 1 still elaborates.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] a_sh, a_nxt;
  logic [WIDTH-1:0] b_sh, b_nxt;
  logic [WIDTH-1:0] sum_sh, sum_nxt;
  logic [WIDTH-1:0] out_sum_nxt;
  logic             out_vld_nxt;

  // Next-state and serial outputs; operands shift right so bit 0 is always the current bit[cnt].
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    a_nxt       = a_sh;
    b_nxt       = b_sh;
    sum_nxt     = sum_sh;
    out_sum_nxt = out_sum;
    out_vld_nxt = 1'b0;
    in_rdy      = (state == IDLE);
    ser_vld     = 1'b0;
    ser_a       = 1'b0;
    ser_b       = 1'b0;
    ser_last    = 1'b0;
    case (state)
      IDLE: begin
        if (in_vld) begin
          a_nxt     = in_a;
          b_nxt     = in_b;
          sum_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // A held cycle is a bubble: nothing advances and the adder sees no valid beat.
        if (!hold) begin
          ser_vld  = 1'b1;
          ser_a    = a_sh[0];
          ser_b    = b_sh[0];
          ser_last = (cnt == CW'(WIDTH - 1));
          a_nxt    = a_sh >> 1;
          b_nxt    = b_sh >> 1;
          // Sum bits arrive LSB first, so each enters at the MSB and walks down.
          sum_nxt             = sum_sh >> 1;
          sum_nxt[WIDTH-1]    = ser_sum;
          cnt_nxt             = cnt + CW'(1);
          if (ser_last) begin
            // Carry out of the MSB is left in the adder, which ser_last clears.
            out_sum_nxt = sum_nxt;
            out_vld_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      out_sum <= '0;
      out_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      a_sh    <= a_nxt;
      b_sh    <= b_nxt;
      sum_sh  <= sum_nxt;
      out_sum <= out_sum_nxt;
      out_vld <= out_vld_nxt;
    end
  end

endmodule

// File: doc/serial_adder_driver.md
SERIAL_ADDER_DRIVER -- requirements
Module: serial_adder_driver

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range WIDTH >= 1.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_vld  input  1  parallel operand pair offered.
REQ-005 in_rdy  output  1  block can accept an operand pair.
REQ-006 in_a  input  WIDTH  operand A.
REQ-007 in_b  input  WIDTH  operand B.
REQ-008 hold  input  1  stall request: insert a bubble (no valid bit) this cycle.
REQ-009 ser_vld  output  1  serial bit pair valid; drives the serial adder's vld.
REQ-010 ser_a  output  1  serial bit of A, LSB first.
REQ-011 ser_b  output  1  serial bit of B, LSB first.
REQ-012 ser_last  output  1  current bit pair is the MSB.
REQ-013 ser_sum  input  1  serial sum bit returned by the adder, combinationally valid in the same cycle as ser_vld.
REQ-014 out_vld  output  1  one-cycle pulse: out_sum updated.
REQ-015 out_sum  output  WIDTH  assembled sum, (in_a + in_b) mod 2^WIDTH.

Function
REQ-016 The block SHALL implement the FSM states IDLE and SHIFT.
REQ-017 in_rdy SHALL be 1 exactly when state is IDLE.
REQ-018 Handshake: on a posedge with in_vld & in_rdy, the block SHALL latch in_a/in_b into shift registers, clear the bit counter, and go to SHIFT.
REQ-019 In SHIFT, ser_vld SHALL be 1 when hold = 0 and 0 when hold = 1; in IDLE, ser_vld SHALL be 0 and hold is ignored.
REQ-020 ser_a/ser_b SHALL present bit[cnt] of the latched operands while ser_vld = 1, and SHALL be 0 while ser_vld = 0.
REQ-021 ser_last SHALL be 1 only when ser_vld = 1 and cnt = WIDTH-1; for WIDTH = 1 it is 1 on the first beat.
REQ-022 On every posedge with ser_vld = 1, the block SHALL shift ser_sum in at the MSB of the sum shift register (LSB-first assembly) and increment cnt.
REQ-023 The hold = 1 cycles in SHIFT SHALL leave cnt, the operand shift registers, and the sum register unchanged.
REQ-024 On the posedge with ser_last = 1, the block SHALL load out_sum from the completed shift register, pulse out_vld for the following cycle, and return to IDLE.
REQ-025 With no hold, the block SHALL present beats in cycles T+1..T+WIDTH after a handshake at edge T; out_vld SHALL be high in cycle T+WIDTH+1, in_rdy SHALL be high in the same cycle, and throughput SHALL be one operation per WIDTH+1 cycles.
REQ-026 out_sum SHALL hold its value until the next completed operation; the carry out of the MSB SHALL be discarded.
REQ-027 in_a/in_b changes after the handshake SHALL have no effect on the operation in flight.
REQ-028 The block SHALL rely on ser_last to clear the downstream adder's carry; the block SHALL emit exactly WIDTH valid beats per operation.

Reset
REQ-029 While rst = 0, state SHALL be IDLE, cnt 0, shift registers 0, out_sum 0, out_vld 0, ser_vld/ser_a/ser_b/ser_last 0, and in_rdy 1; no handshake SHALL be taken.
REQ-030 Reset during SHIFT SHALL abort the operation immediately (asynchronously), with no out_vld; the downstream adder SHALL share the same reset.

Verification
REQ-031 WIDTH=8, 8'h03+8'h05, hold=0 -> ser_a 1,1,0,0,0,0,0,0; ser_b 1,0,1,0,...; ser_last on 8th beat; out_sum=8'h08, out_vld at T+9.
REQ-032 8'hFF+8'h01 then 8'h01+8'h01 -> out_sum 8'h00, then 8'h02 (carry cleared by ser_last).
REQ-033 8'hA5+8'h5A, hold=1 during beats 3-5 -> ser_vld low for 3 cycles, still 8 valid beats, out_sum=8'hFF, out_vld at T+12.
REQ-034 in_vld held high with new operands while busy -> in_rdy 0 through SHIFT; second pair accepted in the out_vld cycle; both results correct.
REQ-035 rst=0 asserted at beat 4 of an operation, then 8'h10+8'h20 -> all outputs 0 immediately, no out_vld for the aborted operation, then out_sum=8'h30.
REQ-036 WIDTH=1, 1+1 -> single beat with ser_last=1, out_sum=1'b0.
